// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared constants for the multicycle control unit.
// State codes, opcode constants and the encodings of pc_src, reg_dst and
// com_format. All opcode constants are on the low 6 opcode bits.
package cpu_ctrl_pkg;

  // FSM state codes (also visible on the debug state port)
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd7;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // pc_src encodings
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b10;

  // reg_dst encodings
  localparam logic [1:0] REG_DST_RD  = 2'b00;
  localparam logic [1:0] REG_DST_RT  = 2'b01;
  localparam logic [1:0] REG_DST_IMM = 2'b10;

  // com_format encodings
  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_J = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational decode of the latched opcode op_q.
// Ports:
//   op_q       in   latched opcode (OPW bits, only low 6 bits are defined)
//   com_format out  instruction format class
//   op_sel     out  ALU operation
//   ext_sel    out  1 = sign extend immediate
//   b_src      out  1 = immediate on ALU B
//   reg_dst    out  destination register select
//   wb_src     out  1 = memory data to register file
//   is_lw/is_sw/is_j/is_beq  out  opcode class flags for the FSM
// Opcodes with any bit above bit 5 set are illegal and decode as a plain
// format-00 register operation.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int OPSELW = 4
) (
  input  logic [OPW-1:0]    op_q,
  output logic [1:0]        com_format,
  output logic [OPSELW-1:0] op_sel,
  output logic              ext_sel,
  output logic              b_src,
  output logic [1:0]        reg_dst,
  output logic              wb_src,
  output logic              is_lw,
  output logic              is_sw,
  output logic              is_j,
  output logic              is_beq
);

  logic [5:0] op;
  logic       legal;

  assign op = op_q[5:0];

  generate
    if (OPW > 6) begin : g_wide
      assign legal = ~|op_q[OPW-1:6];
    end else begin : g_narrow
      assign legal = 1'b1;
    end
  endgenerate

  assign is_lw  = legal && (op == OP_LW);
  assign is_sw  = legal && (op == OP_SW);
  assign is_j   = legal && (op == OP_J);
  assign is_beq = legal && (op == OP_BEQ);

  always_comb begin
    com_format = FMT_R;
    op_sel     = '0;
    ext_sel    = 1'b0;
    b_src      = 1'b0;
    reg_dst    = REG_DST_RT;
    wb_src     = 1'b0;
    if (legal) begin
      if (op[5] || op[3] || op[2] || (op[1:0] == 2'b01)) begin
        com_format = FMT_I;
      end else if (op[5:1] == 5'b00001) begin
        com_format = FMT_J;
      end

      if (com_format == FMT_I) begin
        op_sel = OPSELW'(op[3:0]);
      end
      // memory and branch ops need a fixed ALU function, not their low bits
      if (op == OP_SW) begin
        op_sel = OPSELW'(4'b1011);
      end else if (op == OP_LW) begin
        op_sel = OPSELW'(4'b1010);
      end else if (op == OP_BEQ) begin
        op_sel = OPSELW'(4'b0010);
      end

      b_src   = op[3] && (op != OP_BEQ);
      ext_sel = (op == OP_ADDI) || (op == OP_SLTI);

      if (op[3]) begin
        reg_dst = REG_DST_IMM;
      end
      if ((op == 6'b000001) || (op[5:1] == 5'b00001)) begin
        reg_dst = REG_DST_RD;
      end

      wb_src = (op == OP_LW);
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle CPU control FSM.
// Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
// Memory phases (FETCH, MEM) wait on mem_ready; a bounded wait counter moves
// the core into a sticky FAULT state if memory hangs.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode              opcode from the instruction register (latched in DECODE)
//   zero                ALU zero flag (used by BEQ in EXEC)
//   mem_ready           memory completes the current access this cycle
//   ir_write, pc_write  register load enables
//   pc_src, reg_dst, reg_write, ext_sel, op_sel, b_src  datapath selects
//   mem_read, mem_write memory strobes
//   wb_src, com_format  write-back select, format class
//   instr_done          pulse on the final cycle of an instruction
//   fault               sticky memory timeout flag
//   state               current state (debug)
// All outputs are forced to zero while rst is high.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW      = 6,
  parameter int OPSELW   = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              ir_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic [1:0]        reg_dst,
  output logic              reg_write,
  output logic              ext_sel,
  output logic [OPSELW-1:0] op_sel,
  output logic              b_src,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_src,
  output logic [1:0]        com_format,
  output logic              instr_done,
  output logic              fault,
  output logic [2:0]        state
);

  localparam int WCW = $clog2(WAIT_MAX + 1);

  logic [2:0]     state_reg, state_next;
  logic [OPW-1:0] op_q;
  logic [WCW-1:0] wcnt_reg, wcnt_next;
  logic           fault_reg, fault_next;

  logic [1:0]        d_com_format, d_reg_dst;
  logic [OPSELW-1:0] d_op_sel;
  logic              d_ext_sel, d_b_src, d_wb_src;
  logic              is_lw, is_sw, is_j, is_beq;

  logic       mem_phase, timeout;
  logic       ir_write_c, pc_write_c, reg_write_c;
  logic       mem_read_c, mem_write_c, instr_done_c;
  logic [1:0] pc_src_c;

  ctrl_decode #(
    .OPW    (OPW),
    .OPSELW (OPSELW)
  ) u_decode (
    .op_q       (op_q),
    .com_format (d_com_format),
    .op_sel     (d_op_sel),
    .ext_sel    (d_ext_sel),
    .b_src      (d_b_src),
    .reg_dst    (d_reg_dst),
    .wb_src     (d_wb_src),
    .is_lw      (is_lw),
    .is_sw      (is_sw),
    .is_j       (is_j),
    .is_beq     (is_beq)
  );

  assign mem_phase = (state_reg == ST_FETCH) || (state_reg == ST_MEM);
  // a ready in the last allowed cycle still completes normally
  assign timeout   = mem_phase && !mem_ready && (wcnt_reg == WCW'(WAIT_MAX - 1));

  always_comb begin
    state_next   = state_reg;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = PC_SRC_SEQ;
    reg_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    instr_done_c = 1'b0;

    // counter is zero whenever a memory phase is entered, so it only needs
    // to count inside FETCH/MEM while ready is low
    wcnt_next = '0;
    if (mem_phase && !mem_ready) begin
      wcnt_next = wcnt_reg + 1'b1;
    end

    case (state_reg)
      ST_FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_next = ST_DECODE;
        end else if (timeout) begin
          state_next = ST_FAULT;
        end
      end
      ST_DECODE: begin
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_j) begin
          pc_write_c   = 1'b1;
          pc_src_c     = PC_SRC_JUMP;
          instr_done_c = 1'b1;
          state_next   = ST_FETCH;
        end else if (is_beq) begin
          pc_write_c   = zero;
          pc_src_c     = zero ? PC_SRC_BRANCH : PC_SRC_SEQ;
          instr_done_c = 1'b1;
          state_next   = ST_FETCH;
        end else if (is_lw || is_sw) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEM: begin
        mem_read_c  = is_lw;
        mem_write_c = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            instr_done_c = 1'b1;
            state_next   = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (timeout) begin
          state_next = ST_FAULT;
        end
      end
      ST_WB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_next   = ST_FETCH;
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase

    fault_next = fault_reg || (state_next == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_FETCH;
      op_q      <= '0;
      wcnt_reg  <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      fault_reg <= fault_next;
      if (state_reg == ST_DECODE) begin
        op_q <= opcode;
      end
    end
  end

  assign ir_write   = !rst && ir_write_c;
  assign pc_write   = !rst && pc_write_c;
  assign pc_src     = rst ? 2'b00 : pc_src_c;
  assign reg_write  = !rst && reg_write_c;
  assign mem_read   = !rst && mem_read_c;
  assign mem_write  = !rst && mem_write_c;
  assign instr_done = !rst && instr_done_c;
  assign fault      = !rst && fault_reg;
  assign state      = rst ? 3'b000 : state_reg;
  assign reg_dst    = rst ? 2'b00 : d_reg_dst;
  assign ext_sel    = !rst && d_ext_sel;
  assign op_sel     = rst ? '0 : d_op_sel;
  assign b_src      = !rst && d_b_src;
  assign wb_src     = !rst && d_wb_src;
  assign com_format = rst ? 2'b00 : d_com_format;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl.
// Each instruction is turned into an expected per-cycle trace (state and
// strobes) derived from the instruction's phase sequence, then replayed
// against the DUT while decode selects are checked against a reference
// decode table computed with integer arithmetic.
module tb_multicycle_ctrl;

  localparam int WAIT_MAX = 15;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       ir_write, pc_write, reg_write, ext_sel, b_src;
  logic       mem_read, mem_write, wb_src, instr_done, fault;
  logic [1:0] pc_src, reg_dst, com_format;
  logic [3:0] op_sel;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(
    .OPW      (6),
    .OPSELW   (4),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .ext_sel    (ext_sel),
    .op_sel     (op_sel),
    .b_src      (b_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .wb_src     (wb_src),
    .com_format (com_format),
    .instr_done (instr_done),
    .fault      (fault),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       mr, mw, irw, pcw;
    logic [1:0] pcs;
    logic       rw, done, flt;
    logic       ready, use_op, use_zero, sel_chk, wb_chk;
  } exp_t;

  typedef struct packed {
    logic [1:0] cf;
    logic [3:0] ops;
    logic       ext, bsrc;
    logic [1:0] rdst;
    logic       wb;
  } dec_t;

  exp_t trace[$];

  function automatic exp_t blank(input logic [2:0] st, input logic rdy);
    exp_t e;
    e = '0;
    e.st = st;
    e.ready = rdy;
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // reference decode, straight from the opcode rules
  function automatic dec_t ref_dec(input logic [5:0] op);
    dec_t d;
    int v;
    v = int'(op);
    d = '0;
    if (v >= 32 || (v / 8) % 2 == 1 || (v / 4) % 2 == 1 || v % 4 == 1) d.cf = 2'b01;
    else if (v == 2 || v == 3) d.cf = 2'b10;
    else d.cf = 2'b00;
    if (v == 43) d.ops = 4'd11;
    else if (v == 35) d.ops = 4'd10;
    else if (v == 4) d.ops = 4'd2;
    else if (d.cf == 2'b01) d.ops = 4'(v % 16);
    else d.ops = 4'd0;
    d.bsrc = (v == 4) ? 1'b0 : 1'((v / 8) % 2);
    d.ext  = (v == 8 || v == 10);
    if (v == 1 || v == 2 || v == 3) d.rdst = 2'b00;
    else if ((v / 8) % 2 == 1) d.rdst = 2'b10;
    else d.rdst = 2'b01;
    d.wb = (v == 35);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // memory wait phase: nwait not-ready cycles; too many ends in FAULT
  task automatic stall(input logic [2:0] st, input logic mr, input logic mw,
                       input int nwait, output bit faulted);
    exp_t e;
    for (int i = 0; i < nwait && i < WAIT_MAX; i++) begin
      e = blank(st, 1'b0);
      e.mr = mr;
      e.mw = mw;
      e.sel_chk = (st == 3'd3);
      trace.push_back(e);
    end
    faulted = (nwait >= WAIT_MAX);
    if (faulted) begin
      for (int i = 0; i < 3; i++) begin
        e = blank(3'd7, rbit());
        e.flt = 1'b1;
        trace.push_back(e);
      end
    end
  endtask

  task automatic build(input logic [5:0] op, input logic z, input int fwait, input int mwait);
    exp_t e;
    bit   f;
    bit   is_mem;
    trace.delete();
    stall(3'd0, 1'b1, 1'b0, fwait, f);
    if (f) return;
    e = blank(3'd0, 1'b1);
    e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    trace.push_back(e);
    e = blank(3'd1, rbit());
    e.use_op = 1'b1;
    trace.push_back(e);
    e = blank(3'd2, rbit());
    e.use_zero = 1'b1;
    e.sel_chk = 1'b1;
    if (op == JMP) begin
      e.pcw = 1'b1; e.pcs = 2'b01; e.done = 1'b1;
      trace.push_back(e);
      return;
    end
    if (op == BEQ) begin
      e.pcw = z; e.pcs = z ? 2'b10 : 2'b00; e.done = 1'b1;
      trace.push_back(e);
      return;
    end
    trace.push_back(e);
    is_mem = (op == LW) || (op == SW);
    if (is_mem) begin
      stall(3'd3, op == LW, op == SW, mwait, f);
      if (f) return;
      e = blank(3'd3, 1'b1);
      e.mr = (op == LW); e.mw = (op == SW); e.sel_chk = 1'b1;
      if (op == SW) begin
        e.done = 1'b1;
        trace.push_back(e);
        return;
      end
      trace.push_back(e);
    end
    e = blank(3'd4, rbit());
    e.rw = 1'b1; e.done = 1'b1; e.sel_chk = 1'b1; e.wb_chk = 1'b1;
    trace.push_back(e);
  endtask

  // replay the first 'limit' trace cycles (limit < 0 : whole trace)
  task automatic run(input logic [5:0] op, input logic z, input int limit);
    exp_t  e;
    dec_t  d;
    int    n;
    string t;
    d = ref_dec(op);
    n = (limit < 0 || limit > trace.size()) ? trace.size() : limit;
    for (int c = 0; c < n; c++) begin
      e = trace[c];
      rst = 1'b0;
      mem_ready = e.ready;
      opcode = e.use_op ? op : 6'($urandom);
      zero = e.use_zero ? z : rbit();
      #1;
      t = $sformatf("op=%b cyc=%0d", op, c);
      chk({"state ", t}, 16'(state), 16'(e.st));
      chk({"strobes ", t},
          16'({mem_read, mem_write, ir_write, pc_write, pc_src, reg_write, instr_done, fault}),
          16'({e.mr, e.mw, e.irw, e.pcw, e.pcs, e.rw, e.done, e.flt}));
      if (e.sel_chk) begin
        chk({"selects ", t},
            16'({com_format, op_sel, ext_sel, b_src, reg_dst}),
            16'({d.cf, d.ops, d.ext, d.bsrc, d.rdst}));
      end
      if (e.wb_chk) chk({"wb_src ", t}, 16'(wb_src), 16'(d.wb));
      @(posedge clk);
      #1;
    end
    $display("instr op=%b zero=%0d cycles=%0d of %0d", op, z, n, trace.size());
  endtask

  task automatic instr(input logic [5:0] op, input logic z, input int fwait, input int mwait);
    build(op, z, fwait, mwait);
    run(op, z, -1);
  endtask

  // two reset cycles; every output must read zero while rst is high
  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      opcode = 6'($urandom);
      zero = rbit();
      #1;
      chk("reset outputs",
          16'({state, mem_read, mem_write, ir_write, pc_write, pc_src, reg_write, instr_done, fault}),
          16'd0);
      chk("reset selects",
          16'({com_format, op_sel, ext_sel, b_src, reg_dst, wb_src}), 16'd0);
      @(posedge clk);
      #1;
    end
    $display("reset applied");
  endtask

  logic [5:0] pool [8];

  initial begin
    rst = 1'b1;
    opcode = '0;
    zero = 1'b0;
    mem_ready = 1'b0;
    pool[0] = 6'b000000; pool[1] = LW;   pool[2] = SW;   pool[3] = JMP;
    pool[4] = BEQ;       pool[5] = ADDI; pool[6] = SLTI; pool[7] = 6'b000001;
    @(posedge clk);
    #1;
    do_reset();

    // directed
    instr(6'b000000, 1'b0, 0, 0);
    instr(LW, 1'b0, 0, 2);
    instr(BEQ, 1'b1, 0, 0);
    instr(BEQ, 1'b0, 0, 0);
    instr(ADDI, 1'b0, 0, 0);
    instr(JMP, 1'b0, 1, 0);
    instr(SW, 1'b0, 0, 0);
    instr(6'b000011, 1'b0, 0, 0);
    instr(6'b110101, 1'b1, 2, 0);

    // last-chance ready in FETCH and MEM: no fault
    instr(6'b000000, 1'b0, WAIT_MAX - 1, 0);
    instr(LW, 1'b0, 0, WAIT_MAX - 1);

    // SW aborted by reset in MEM
    build(SW, 1'b0, 0, 5);
    run(SW, 1'b0, 4);
    do_reset();
    instr(ADDI, 1'b0, 0, 0);

    // FETCH timeout -> sticky FAULT, recovered only by reset
    instr(6'b000000, 1'b0, WAIT_MAX, 0);
    do_reset();
    // MEM timeout
    instr(SW, 1'b0, 0, WAIT_MAX);
    do_reset();

    // randomized back-to-back instructions
    for (int k = 0; k < 40; k++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : pool[$urandom_range(0, 7)];
      instr(op, rbit(), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the CPU datapath. It replaces the single-cycle combinational decoder with a state machine that sequences each instruction through fetch, decode, execute, memory and write-back. Memory accesses use a ready handshake, and a bounded wait counter faults the core on a hung memory. It drives the same datapath select lines as before, plus IR/PC write enables and a per-instruction completion pulse.

## Interface
- OPW, 6, opcode width; opcode constants are defined on the low 6 bits, upper bits must be zero for a legal opcode
- OPSELW, 4, ALU op select width
- WAIT_MAX, 15, max consecutive cycles without `mem_ready` before fault (≥1)
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- opcode  in  OPW  opcode field from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  2  00 PC+4, 01 jump target, 10 branch target
- reg_dst  out  2  00 rd-class, 01 rt, 10 imm-format dest
- reg_write  out  1  register file write
- ext_sel  out  1  1 = sign extend
- op_sel  out  OPSELW  ALU operation
- b_src  out  1  1 = immediate to ALU B
- mem_read / mem_write  out  1 each  memory strobes
- wb_src  out  1  1 = memory data to register file
- com_format  out  2  instruction format class
- instr_done  out  1  one-cycle pulse on an instruction's final cycle
- fault  out  1  sticky memory-timeout flag
- state  out  3  current state, for debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.
- FETCH:
  - assert mem_read;
  - on mem_ready, pulse ir_write and pc_write with pc_src=00, then go to DECODE;
  - otherwise stay in FETCH.
- DECODE:
  - opcode is latched into `op_q`;
  - all later select outputs derive from `op_q`, never from live `opcode`.
- Decode of `op_q`:
  - com_format=01 if op[5]|op[3]|op[2]|op[1:0]==01;
  - else com_format=10 if op[5:1]==00001;
  - else com_format=00.
- op_sel:
  - =op[3:0] for format 01, else 0;
  - overrides: SW 101011→1011, LW 100011→1010, BEQ 000100→0010.
- b_src=op[3], except BEQ=0.
- ext_sel=1 only for 001000 and 001010.
- reg_dst:
  - 01 by default;
  - 10 if op[3];
  - 00 if op==000001 or op[5:1]==00001.
- EXEC:
  - J 000010: pc_write, pc_src=01, instr_done, go to FETCH.
  - BEQ: pc_write=zero, pc_src=10 if zero, instr_done, go to FETCH.
  - LW/SW: go to MEM.
  - Other opcodes: go to WB.
- MEM:
  - LW asserts mem_read; SW asserts mem_write;
  - held until mem_ready.
  - On ready: SW pulses instr_done and goes to FETCH; LW goes to WB.
- WB:
  - reg_write=1 for one cycle;
  - wb_src=1 for LW, else 0;
  - instr_done, go to FETCH.
- Outside the states listed above: reg_write, mem_read, mem_write, ir_write, pc_write and instr_done are 0.
- Wait counter `wcnt` (width clog2(WAIT_MAX+1)):
  - cleared on entry to FETCH/MEM and whenever mem_ready=1;
  - increments each FETCH/MEM cycle with mem_ready=0.
  - If wcnt==WAIT_MAX-1 and mem_ready=0, the next state is FAULT.
  - mem_ready in that same cycle wins: normal transition, no fault.
- FAULT:
  - all strobes 0, fault=1;
  - left only by rst.
- Unknown opcodes (upper bits nonzero) execute as format-00 register ops via EXEC→WB; no trap.

## Timing
- All strobes and selects are combinational from state and `op_q`. State, `op_q`, wcnt and fault are registered.
- During rst=1, every output is forced to 0. On the first clk edge with rst=1: state=FETCH, op_q=0, wcnt=0, fault=0.
- Latency with zero-wait memory:
  - J/BEQ: 3 cycles;
  - R/imm ALU: 4 cycles;
  - SW: 4 cycles;
  - LW: 5 cycles.
  - Each memory wait cycle adds 1.
- instr_done is high on exactly the last cycle of each instruction. Back-to-back instructions show no idle cycles.
- rst mid-instruction aborts the instruction with no reg_write or mem_write. The next edge is FETCH.

## Structure
- Package `cpu_ctrl_pkg`: opcode constants (OP_LW, OP_SW, OP_J, OP_BEQ, OP_ADDI-class), state enum, pc_src/reg_dst/com_format encodings.
- Sub-module `ctrl_decode`: purely combinational `op_q` → com_format, op_sel, ext_sel, b_src, reg_dst, wb_src. The FSM top instantiates it and gates the strobes by state.

## Test plan
- Reset, then opcode 000000 with mem_ready=1 constant → states 0,1,2,4; reg_write only in cycle 4; instr_done at cycle 4; reg_dst=01, op_sel=0.
- LW 100011 with mem_ready delayed 2 cycles in MEM → mem_read held 3 MEM cycles; then WB with wb_src=1, op_sel=1010; total 7 cycles.
- BEQ with zero=1, then zero=0 → pc_write=1 with pc_src=10 in EXEC for the first; pc_write=0 for the second; both complete in 3 cycles with b_src=0.
- mem_ready=0 for WAIT_MAX=15 cycles in FETCH → FAULT on cycle 16, fault=1 held. Repeat with mem_ready rising on cycle 15 → DECODE, no fault.
- SW 101011 with rst pulsed during MEM → mem_write=0 during rst; state=FETCH next cycle; reg_write never asserted.
- Opcode 001000 → ext_sel=1, b_src=1, reg_dst=10, com_format=01, op_sel=1000, reg_write in WB.
